// File: rtl/tinycodec_pkg.sv
// Shared types and constants for the tiny codec token path.
package tinycodec_pkg;

  // Token type carried in header bits [7:6]
  typedef enum logic [1:0] {
    TOK_COEF  = 2'b00,
    TOK_EOB   = 2'b01,
    TOK_SHORT = 2'b10,
    TOK_RSVD  = 2'b11
  } tok_type_t;

  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned COEF_W     = 12;
  localparam int unsigned RUN_W      = 6;
  localparam int unsigned POS_W      = 7;

  // Sign-extend a one-byte SHORT payload to a full coefficient
  function automatic logic [COEF_W-1:0] sext_byte(input logic [7:0] b);
    return {{(COEF_W - 8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/rle_token_decoder.sv
// Run-length token unpacker: turns a header/payload byte stream into
// (run, value) pairs, tracks scan position and inserts a fixed idle gap
// after each completed block so the downstream column readout can drain.
module rle_token_decoder
  import tinycodec_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 10
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid_in,
  output logic              byte_ready_out,
  output logic [COEF_W-1:0] value_out,
  output logic [RUN_W-1:0]  run_out,
  output logic              valid_out,
  output logic              block_done_out,
  output logic              err_out
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_HDR    = 2'b00,
    ST_VAL_LO = 2'b01,
    ST_VAL_HI = 2'b10,
    ST_GAP    = 2'b11
  } state_t;

  state_t             state_r,    state_nxt_s;
  logic [POS_W-1:0]   pos_r,      pos_nxt_s;
  logic [RUN_W-1:0]   hdr_run_r,  hdr_run_nxt_s;
  tok_type_t          hdr_type_r, hdr_type_nxt_s;
  logic [7:0]         lo_r,       lo_nxt_s;
  logic [GAP_W-1:0]   gap_r,      gap_nxt_s;

  logic               emit_s;
  logic [RUN_W-1:0]   emit_run_s;
  logic [COEF_W-1:0]  emit_val_s;
  logic               err_set_s;
  logic               done_s;
  logic [POS_W-1:0]   rem_s;
  logic [7:0]         sum_s;

  logic               ready_r;
  logic [COEF_W-1:0]  value_r;
  logic [RUN_W-1:0]   run_r;
  logic               valid_r;
  logic               done_r;
  logic               err_r;

  assign byte_ready_out = ready_r;
  assign value_out      = value_r;
  assign run_out        = run_r;
  assign valid_out      = valid_r;
  assign block_done_out = done_r;
  assign err_out        = err_r;

  // Next-state, token assembly and pair emission / block completion logic
  always_comb begin
    state_nxt_s    = state_r;
    pos_nxt_s      = pos_r;
    hdr_run_nxt_s  = hdr_run_r;
    hdr_type_nxt_s = hdr_type_r;
    lo_nxt_s       = lo_r;
    gap_nxt_s      = gap_r;
    emit_s         = 1'b0;
    emit_run_s     = hdr_run_r;
    emit_val_s     = {COEF_W{1'b0}};
    err_set_s      = 1'b0;
    done_s         = 1'b0;
    // Slots left after the current position; used by EOB and by the overshoot clamp
    rem_s          = POS_W'(BLOCK_SIZE - 1) - pos_r;

    case (state_r)
      ST_HDR: begin
        if (byte_valid_in) begin
          hdr_run_nxt_s  = byte_in[5:0];
          hdr_type_nxt_s = tok_type_t'(byte_in[7:6]);
          case (tok_type_t'(byte_in[7:6]))
            TOK_COEF:  state_nxt_s = ST_VAL_LO;
            TOK_SHORT: state_nxt_s = ST_VAL_LO;
            TOK_EOB: begin
              emit_s     = 1'b1;
              emit_run_s = rem_s[RUN_W-1:0];
            end
            TOK_RSVD:  err_set_s = 1'b1;
            default:   err_set_s = 1'b1;
          endcase
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_VAL_LO: begin
        if (byte_valid_in) begin
          if (hdr_type_r == TOK_SHORT) begin
            emit_s      = 1'b1;
            emit_val_s  = sext_byte(byte_in);
            state_nxt_s = ST_HDR;
          end else begin
            lo_nxt_s    = byte_in;
            state_nxt_s = ST_VAL_HI;
          end
        end else begin
          state_nxt_s = ST_VAL_LO;
        end
      end
      ST_VAL_HI: begin
        if (byte_valid_in) begin
          emit_s      = 1'b1;
          emit_val_s  = {byte_in[3:0], lo_r};
          state_nxt_s = ST_HDR;
          if (byte_in[7:4] != 4'd0) begin
            err_set_s = 1'b1;
          end else begin
            err_set_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_VAL_HI;
        end
      end
      ST_GAP: begin
        if (gap_r == {GAP_W{1'b0}}) begin
          state_nxt_s = ST_HDR;
        end else begin
          gap_nxt_s = gap_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_HDR;
      end
    endcase

    sum_s = {1'b0, pos_r} + {2'b00, emit_run_s} + 8'd1;

    if (emit_s) begin
      if (sum_s >= 8'(BLOCK_SIZE)) begin
        done_s      = 1'b1;
        pos_nxt_s   = {POS_W{1'b0}};
        state_nxt_s = ST_GAP;
        gap_nxt_s   = GAP_W'(GAP_CYCLES - 1);
        // A run that spills past the block end is clamped to the last slot
        if (sum_s > 8'(BLOCK_SIZE)) begin
          err_set_s  = 1'b1;
          emit_run_s = rem_s[RUN_W-1:0];
        end else begin
          emit_run_s = emit_run_s;
        end
      end else begin
        pos_nxt_s = sum_s[POS_W-1:0];
      end
    end else begin
      pos_nxt_s = pos_nxt_s;
    end
  end

  // State, position, gap counter and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= ST_HDR;
      pos_r      <= {POS_W{1'b0}};
      hdr_run_r  <= {RUN_W{1'b0}};
      hdr_type_r <= TOK_COEF;
      lo_r       <= 8'd0;
      gap_r      <= {GAP_W{1'b0}};
      ready_r    <= 1'b1;
      value_r    <= {COEF_W{1'b0}};
      run_r      <= {RUN_W{1'b0}};
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pos_r      <= pos_nxt_s;
      hdr_run_r  <= hdr_run_nxt_s;
      hdr_type_r <= hdr_type_nxt_s;
      lo_r       <= lo_nxt_s;
      gap_r      <= gap_nxt_s;
      ready_r    <= (state_nxt_s != ST_GAP);
      valid_r    <= emit_s;
      done_r     <= done_s;
      err_r      <= err_r | err_set_s;
      if (emit_s) begin
        value_r <= emit_val_s;
        run_r   <= emit_run_s;
      end else begin
        value_r <= value_r;
        run_r   <= run_r;
      end
    end
  end

endmodule

// File: tb/tb_rle_token_decoder.sv
// Directed self-checking bench for rle_token_decoder.
module tb_rle_token_decoder;

  logic        clk_in;
  logic        rst_n_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_ready_out;
  logic [11:0] value_out;
  logic [5:0]  run_out;
  logic        valid_out;
  logic        block_done_out;
  logic        err_out;

  int checks;
  int failures;
  int cyc;

  rle_token_decoder #(.GAP_CYCLES(10)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_ready_out (byte_ready_out),
    .value_out      (value_out),
    .run_out        (run_out),
    .valid_out      (valid_out),
    .block_done_out (block_done_out),
    .err_out        (err_out)
  );

  // Free-running clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Cycle counter for latency measurements
  always @(posedge clk_in) cyc <= cyc + 1;

  // Watchdog against any hang
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for ready (bounded), present one byte for one cycle, sample #1 after the edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!byte_ready_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (!byte_ready_out) check_eq("ready_wait", {31'd0, byte_ready_out}, 32'd1);
    @(negedge clk_in);
    byte_in       = b;
    byte_valid_in = 1'b1;
    @(posedge clk_in); #1;
    byte_valid_in = 1'b0;
    byte_in       = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic check_pair(input string tag, input logic [5:0] run, input logic [11:0] val,
                            input logic done);
    check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check_eq({tag, "_run"},   {26'd0, run_out}, {26'd0, run});
    check_eq({tag, "_value"}, {20'd0, value_out}, {20'd0, val});
    check_eq({tag, "_done"},  {31'd0, block_done_out}, {31'd0, done});
  endtask

  int gap_cnt;
  int t1;
  int t2;

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    rst_n_in      = 1'b0;
    byte_in       = 8'd0;
    byte_valid_in = 1'b0;
    idle(3);
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    check_eq("rst_ready", {31'd0, byte_ready_out}, 32'd1);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_done",  {31'd0, block_done_out}, 32'd0);
    check_eq("rst_err",   {31'd0, err_out}, 32'd0);
    check_eq("rst_value", {20'd0, value_out}, 32'd0);
    check_eq("rst_run",   {26'd0, run_out}, 32'd0);

    // COEF run 0, value 0x134 -> pos 1
    send_byte(8'h00);
    check_eq("coef_hdr_novalid", {31'd0, valid_out}, 32'd0);
    send_byte(8'h34);
    check_eq("coef_lo_novalid", {31'd0, valid_out}, 32'd0);
    send_byte(8'h01);
    check_pair("coef1", 6'd0, 12'h134, 1'b0);
    idle(1);
    check_eq("coef1_pulse", {31'd0, valid_out}, 32'd0);

    // SHORT run 3, value -2 with idle cycles mid-token -> pos 5
    idle(2);
    send_byte(8'h83);
    idle(3);
    check_eq("short_idle_novalid", {31'd0, valid_out}, 32'd0);
    send_byte(8'hFE);
    check_pair("short1", 6'd3, 12'hFFE, 1'b0);

    // EOB at pos 5 -> run 58, block done, then 10 cycles not ready
    send_byte(8'h40);
    check_pair("eob_pos5", 6'd58, 12'h000, 1'b1);
    check_eq("eob_ready_low", {31'd0, byte_ready_out}, 32'd0);
    check_eq("eob_err", {31'd0, err_out}, 32'd0);
    gap_cnt = 0;
    while (!byte_ready_out && gap_cnt < 50) begin
      @(posedge clk_in); #1;
      gap_cnt++;
    end
    check_eq("gap_len", gap_cnt, 32'd10);

    // COEF run 0 then EOB -> run 62
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h00);
    check_pair("coef2", 6'd0, 12'h005, 1'b0);
    send_byte(8'h40);
    check_pair("eob_pos1", 6'd62, 12'h000, 1'b1);

    // Back-to-back EOB at pos 0 -> run 63 each, spaced GAP_CYCLES+1
    send_byte(8'h40);
    t1 = cyc;
    check_pair("eob0_a", 6'd63, 12'h000, 1'b1);
    send_byte(8'h40);
    t2 = cyc;
    check_pair("eob0_b", 6'd63, 12'h000, 1'b1);
    check_eq("eob_spacing", t2 - t1, 32'd11);

    // Reach pos 60, then COEF run 10 overshoots
    send_byte(8'hBB);
    send_byte(8'h01);
    check_pair("short59", 6'd59, 12'h001, 1'b0);
    check_eq("pre_ovr_err", {31'd0, err_out}, 32'd0);
    send_byte(8'h0A);
    send_byte(8'h07);
    send_byte(8'h00);
    check_pair("overshoot", 6'd3, 12'h007, 1'b1);
    check_eq("ovr_err", {31'd0, err_out}, 32'd1);
    send_byte(8'h83);
    send_byte(8'hFE);
    check_pair("post_ovr", 6'd3, 12'hFFE, 1'b0);
    check_eq("err_sticky", {31'd0, err_out}, 32'd1);

    // Reset between COEF lo and hi bytes: partial token dropped, pos back to 0
    send_byte(8'h00);
    send_byte(8'h34);
    @(negedge clk_in) rst_n_in = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("midrst_err", {31'd0, err_out}, 32'd0);
    idle(2);
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check_eq("postrst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("postrst_ready", {31'd0, byte_ready_out}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h22);
    send_byte(8'h00);
    check_pair("postrst_coef", 6'd0, 12'h022, 1'b0);
    send_byte(8'h40);
    check_pair("postrst_eob", 6'd62, 12'h000, 1'b1);
    check_eq("postrst_err", {31'd0, err_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
